// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier core.
// Operands stay in the Montgomery domain until a final multiply by 1 converts the result back.
module modexp_ctrl #(
  parameter int N     = 1024,
  parameter int E_W   = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_r,
  input  logic [N-1:0]     in_m,
  input  logic [E_W-1:0]   in_e,
  input  logic [LEN_W-1:0] in_elen,
  output logic             mont_start,
  output logic [N-1:0]     mont_a,
  output logic [N-1:0]     mont_b,
  output logic [N-1:0]     mont_m,
  input  logic [N-1:0]     mont_result,
  input  logic             mont_done,
  output logic [N-1:0]     result,
  output logic             done,
  output logic             busy
);

  localparam int IDX_W = $clog2(E_W);

  // IDLE wait | SQ_* square acc | MUL_* acc*x | NEXT step to next bit | POST_* acc*1 back to plain
  typedef enum logic [2:0] {
    IDLE, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, NEXT, POST_GO, POST_WAIT
  } state_t;

  state_t           state_q;
  logic [N-1:0]     acc_q, x_q, m_q, a_q, b_q, result_q;
  logic [E_W-1:0]   e_q;
  logic [LEN_W-1:0] i_q;
  logic             mont_start_q, done_q, busy_q;
  logic [LEN_W-1:0] elen_d;
  logic             e_bit;

  always_comb begin
    elen_d = in_elen;
    if (in_elen > LEN_W'(E_W)) elen_d = LEN_W'(E_W);
  end

  // i_q has already been decremented when the bit is examined, so it is the bit index.
  assign e_bit = e_q[i_q[IDX_W-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      x_q          <= '0;
      m_q          <= '0;
      e_q          <= '0;
      i_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= in_x;
            acc_q   <= in_r;
            m_q     <= in_m;
            e_q     <= in_e;
            i_q     <= elen_d;
            busy_q  <= 1'b1;
            state_q <= (elen_d == '0) ? POST_GO : SQ_GO;
          end
        end
        SQ_GO: begin
          a_q          <= acc_q;
          b_q          <= acc_q;
          mont_start_q <= 1'b1;
          i_q          <= i_q - LEN_W'(1);
          state_q      <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mont_done) begin
            acc_q   <= mont_result;
            state_q <= e_bit ? MUL_GO : NEXT;
          end
        end
        MUL_GO: begin
          a_q          <= acc_q;
          b_q          <= x_q;
          mont_start_q <= 1'b1;
          state_q      <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mont_done) begin
            acc_q   <= mont_result;
            state_q <= NEXT;
          end
        end
        NEXT: state_q <= (i_q != '0) ? SQ_GO : POST_GO;
        POST_GO: begin
          a_q          <= acc_q;
          b_q          <= N'(1);
          mont_start_q <= 1'b1;
          state_q      <= POST_WAIT;
        end
        POST_WAIT: begin
          if (mont_done) begin
            result_q <= mont_result;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mont_start = mont_start_q;
  assign mont_a     = a_q;
  assign mont_b     = b_q;
  assign mont_m     = m_q;
  assign result     = result_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery core with random latency, plain-domain
// modexp reference, and a scoreboard popped by a monitor on every done pulse.
module tb_modexp_ctrl;
  localparam int N = 1024, E_W = 1024, LEN_W = 11;

  logic             clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [N-1:0]     in_x = '0, in_r = '0, in_m = '0;
  logic [E_W-1:0]   in_e = '0;
  logic [LEN_W-1:0] in_elen = '0;
  logic             mont_start, mont_done, done, busy;
  logic [N-1:0]     mont_a, mont_b, mont_m, mont_result, result;

  logic             core_done = 1'b0, core_pend = 1'b0, spur_done = 1'b0;
  int               core_lat = 0;
  logic [N-1:0]     core_res = '0;

  assign mont_done   = core_done | spur_done;
  assign mont_result = core_done ? core_res : {(N/32){32'hDEADBEEF}};

  modexp_ctrl #(.N(N), .E_W(E_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] res;
    int           pulses;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0, n_done = 0, pulse_cnt = 0;
  logic done_prev = 1'b0;
  logic [N-1:0] m_t, r_t;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", nm, act[127:0], exp[127:0]);
    end
  endtask

  // Radix-2 Montgomery product a*b*2^-N mod m, a,b < m.
  function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, b, m);
    logic [N+1:0] t;
    t = '0;
    for (int k = 0; k < N; k++) begin
      if (a[k]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] powmod(input logic [N-1:0] x, input logic [E_W-1:0] e,
                                          input logic [N-1:0] m);
    logic [2*N-1:0] r, xx, mm;
    r  = 1;
    xx = {{N{1'b0}}, x};
    mm = {{N{1'b0}}, m};
    for (int k = E_W - 1; k >= 0; k--) begin
      r = (r * r) % mm;
      if (e[k]) r = (r * xx) % mm;
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] to_mont(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [2*N-1:0] t, mm;
    t  = {x, {N{1'b0}}};
    mm = {{N{1'b0}}, m};
    t  = t % mm;
    return t[N-1:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_done <= 1'b0;
      core_pend <= 1'b0;
      core_lat  <= 0;
    end else begin
      core_done <= 1'b0;
      if (mont_start) begin
        core_res  <= mont_mul(mont_a, mont_b, mont_m);
        core_lat  <= int'($urandom_range(0, 3));
        core_pend <= 1'b1;
      end else if (core_pend) begin
        if (core_lat == 0) begin
          core_done <= 1'b1;
          core_pend <= 1'b0;
        end else core_lat <= core_lat - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t ex;
    if (mont_start) check("one_outstanding", N'(core_pend), N'(0));
    if (done_prev) check("done_width", N'(done), N'(0));
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no done");
      end else begin
        ex = sb.pop_front();
        check({ex.name, "_result"}, result, ex.res);
        check({ex.name, "_pulses"}, N'(pulse_cnt), N'(ex.pulses));
        check({ex.name, "_busy_at_done"}, N'(busy), N'(0));
      end
    end
    done_prev = done;
    if (start && !busy && resetn) pulse_cnt = 0;
    else if (mont_start) pulse_cnt++;
  end

  task automatic issue(input logic [N-1:0] x, r, m, input logic [E_W-1:0] e,
                       input logic [LEN_W-1:0] elen, input logic spur);
    @(posedge clk); #1;
    in_x = x; in_r = r; in_m = m; in_e = e; in_elen = elen;
    start = 1'b1; spur_done = spur;
    @(posedge clk); #1;
    start = 1'b0; spur_done = 1'b0;
  endtask

  task automatic wait_sb(input string nm);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles required done", nm, cyc);
      sb.delete();
    end
  endtask

  task automatic wait_pulses(input string nm, input int target);
    int cyc;
    cyc = 0;
    while (pulse_cnt < target && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    if (pulse_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_pulse_timeout: got %0d pulses required %0d", nm, pulse_cnt, target);
    end
  endtask

  task automatic run(input string nm, input logic [N-1:0] xp, input logic [E_W-1:0] e,
                     input logic [LEN_W-1:0] elen, input logic [N-1:0] exp_res,
                     input int exp_p, input logic spur);
    sb.push_back('{nm, exp_res, exp_p});
    issue(to_mont(xp, m_t), r_t, m_t, e, elen, spur);
    wait_sb(nm);
  endtask

  initial begin
    logic [N-1:0]   xr;
    logic [E_W-1:0] er;
    m_t = (N'(1) << (N - 1)) | (N'(1) << 512) | N'(12345);
    r_t = to_mont(N'(1), m_t);

    #1;
    check("rst_mont_start", N'(mont_start), N'(0));
    check("rst_mont_a", mont_a, N'(0));
    check("rst_mont_b", mont_b, N'(0));
    check("rst_mont_m", mont_m, N'(0));
    check("rst_result", result, N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_busy", N'(busy), N'(0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Stray core done while idle must not produce anything.
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) check("idle_spur_busy", N'(busy), N'(0));

    run("t1_e0", N'(5), E_W'(0), LEN_W'(0), N'(1), 1, 1'b0);

    sb.push_back('{"t2_e1", N'(16'h1234), 3});
    issue(to_mont(N'(16'h1234), m_t), r_t, m_t, E_W'(1), LEN_W'(1), 1'b0);
    @(negedge clk);
    check("t2_result_held", result, N'(1));
    check("t2_mont_m", mont_m, m_t);
    check("t2_busy", N'(busy), N'(1));
    wait_sb("t2_e1");

    // Upper exponent bits beyond elen are set and must be ignored; core done coincides with start.
    er = '1;
    er[2:0] = 3'b101;
    run("t3_e5", N'(3), er, LEN_W'(3), N'(243), 6, 1'b1);

    for (int k = 0; k < N / 32; k++) xr[k*32 +: 32] = $urandom();
    for (int k = 0; k < E_W / 32; k++) er[k*32 +: 32] = $urandom();
    xr = xr % m_t;
    run("t4_rand", xr, er, LEN_W'(1024), powmod(xr, er, m_t), 1025 + $countones(er), 1'b0);

    run("t_clamp", N'(3), E_W'(5), LEN_W'(2047), N'(243), 1027, 1'b0);

    sb.push_back('{"t5_restart", N'(243), 6});
    issue(to_mont(N'(3), m_t), r_t, m_t, E_W'(5), LEN_W'(3), 1'b0);
    wait_pulses("t5", 2);
    issue(to_mont(N'(7), m_t), r_t, m_t, E_W'(9), LEN_W'(4), 1'b0);
    @(negedge clk) check("t5_busy_kept", N'(busy), N'(1));
    wait_sb("t5_restart");
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t5_busy_after", N'(busy), N'(0));
    check("t5_result_after", result, N'(243));

    issue(to_mont(N'(3), m_t), r_t, m_t, E_W'(5), LEN_W'(3), 1'b0);
    wait_pulses("t6", 2);
    #1 resetn = 1'b0;
    #1;
    check("t6_mont_start", N'(mont_start), N'(0));
    check("t6_mont_a", mont_a, N'(0));
    check("t6_mont_b", mont_b, N'(0));
    check("t6_mont_m", mont_m, N'(0));
    check("t6_result", result, N'(0));
    check("t6_done", N'(done), N'(0));
    check("t6_busy", N'(busy), N'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    run("t6_rerun", N'(3), E_W'(5), LEN_W'(3), N'(243), 6, 1'b0);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
